// File: rtl/pio_gpio_port_pkg.sv
// Shared sizing constants and small helpers for the PIO pad-side GPIO stage.
package pio_gpio_port_pkg;

  localparam int PIO_NUM_SM    = 4;
  localparam int PIO_PIN_COUNT = 32;
  localparam int PIO_WORD_W    = 32;

  typedef logic [PIO_WORD_W-1:0] pio_word_t;

  // Bits an SM claims this cycle: its mask, gated by its valid strobe.
  function automatic pio_word_t claim_bits(input logic valid, input pio_word_t mask);
    return valid ? mask : '0;
  endfunction

endpackage

// File: rtl/pio_gpio_sync.sv
// Two-flop input synchronizer with per-bit bypass of the second flop.
// Both stages always clock, so changing the bypass select exposes at most one stale sample.
module pio_gpio_sync
  import pio_gpio_port_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  pio_word_t pad_in,
  input  pio_word_t bypass,
  output pio_word_t gpio
);

  pio_word_t sync_p1;
  pio_word_t sync_p2;

  // Stage 1 samples the raw pads, stage 2 re-samples stage 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p1 <= '0;
      sync_p2 <= '0;
    end else begin
      sync_p1 <= pad_in;
      sync_p2 <= sync_p1;
    end
  end

  // bypass is a static per-pin configuration select between the two flop outputs.
  assign gpio = (sync_p1 & bypass) | (sync_p2 & ~bypass);

endmodule

// File: rtl/pio_gpio_port.sv
// Pad-side merge of all SM pin/pindir writes plus the CPU force path into
// registered OUT/OE state, with sticky per-pin SM collision flags and input sync.
module pio_gpio_port
  import pio_gpio_port_pkg::*;
#(
  parameter int NUM_SM    = PIO_NUM_SM,
  parameter int PIN_COUNT = PIO_PIN_COUNT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_SM-1:0]            in_smWriteValid,
  input  logic [NUM_SM*PIO_WORD_W-1:0] in_pinsWriteData,
  input  logic [NUM_SM*PIO_WORD_W-1:0] in_pinsWriteMask,
  input  logic [NUM_SM*PIO_WORD_W-1:0] in_pinDirsWriteData,
  input  logic [NUM_SM*PIO_WORD_W-1:0] in_pinDirsWriteMask,
  input  logic                         in_cpuWriteValid,
  input  logic [PIN_COUNT-1:0]         in_cpuPins,
  input  logic [PIN_COUNT-1:0]         in_cpuDirs,
  input  logic [PIN_COUNT-1:0]         in_syncBypass,
  input  logic [PIN_COUNT-1:0]         in_conflictClear,
  input  logic [PIN_COUNT-1:0]         in_padIn,
  output logic [PIN_COUNT-1:0]         out_padOut,
  output logic [PIN_COUNT-1:0]         out_padOe,
  output logic [PIN_COUNT-1:0]         out_GPIO,
  output logic [PIN_COUNT-1:0]         out_conflict
);

  pio_word_t pins_nxt_p0;
  pio_word_t dirs_nxt_p0;
  pio_word_t pins_seen_p0;
  pio_word_t dirs_seen_p0;
  pio_word_t pins_multi_p0;
  pio_word_t dirs_multi_p0;
  pio_word_t pin_claim;
  pio_word_t dir_claim;

  // Merge: CPU value (or hold) first, then SMs in ascending order so the highest index wins.
  always_comb begin
    pins_nxt_p0   = in_cpuWriteValid ? in_cpuPins : out_padOut;
    dirs_nxt_p0   = in_cpuWriteValid ? in_cpuDirs : out_padOe;
    pins_seen_p0  = '0;
    dirs_seen_p0  = '0;
    pins_multi_p0 = '0;
    dirs_multi_p0 = '0;
    pin_claim     = '0;
    dir_claim     = '0;
    for (int i = 0; i < NUM_SM; i++) begin
      pin_claim     = claim_bits(in_smWriteValid[i], in_pinsWriteMask[PIO_WORD_W*i +: PIO_WORD_W]);
      dir_claim     = claim_bits(in_smWriteValid[i], in_pinDirsWriteMask[PIO_WORD_W*i +: PIO_WORD_W]);
      pins_nxt_p0   = (pins_nxt_p0 & ~pin_claim)
                    | (in_pinsWriteData[PIO_WORD_W*i +: PIO_WORD_W] & pin_claim);
      dirs_nxt_p0   = (dirs_nxt_p0 & ~dir_claim)
                    | (in_pinDirsWriteData[PIO_WORD_W*i +: PIO_WORD_W] & dir_claim);
      // A bit already claimed by a lower SM and claimed again is a collision.
      pins_multi_p0 = pins_multi_p0 | (pins_seen_p0 & pin_claim);
      dirs_multi_p0 = dirs_multi_p0 | (dirs_seen_p0 & dir_claim);
      pins_seen_p0  = pins_seen_p0 | pin_claim;
      dirs_seen_p0  = dirs_seen_p0 | dir_claim;
    end
  end

  // ---- stage p0 -> p1: registered pad state and sticky collisions (set beats clear) ----
  always_ff @(posedge clk) begin
    if (reset) begin
      out_padOut   <= '0;
      out_padOe    <= '0;
      out_conflict <= '0;
    end else begin
      out_padOut   <= pins_nxt_p0;
      out_padOe    <= dirs_nxt_p0;
      out_conflict <= (out_conflict & ~in_conflictClear) | pins_multi_p0 | dirs_multi_p0;
    end
  end

  pio_gpio_sync u_sync (
    .clk    (clk),
    .reset  (reset),
    .pad_in (in_padIn),
    .bypass (in_syncBypass),
    .gpio   (out_GPIO)
  );

endmodule

// File: tb/tb_pio_gpio_port.sv
// Randomized and directed bench for pio_gpio_port against a per-bit behavioural model.
module tb_pio_gpio_port;

  localparam int NUM_SM = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset;
  logic [NUM_SM-1:0]    sm_valid;
  logic [31:0]          pd [NUM_SM];
  logic [31:0]          pm [NUM_SM];
  logic [31:0]          dd [NUM_SM];
  logic [31:0]          dm [NUM_SM];
  logic [NUM_SM*32-1:0] pd_bus, pm_bus, dd_bus, dm_bus;
  logic                 cpu_valid;
  logic [31:0]          cpu_pins, cpu_dirs, sync_bypass, conflict_clear, pad_in;
  logic [31:0]          pad_out, pad_oe, gpio, conflict;

  for (genvar g = 0; g < NUM_SM; g++) begin : g_bus
    assign pd_bus[32*g +: 32] = pd[g];
    assign pm_bus[32*g +: 32] = pm[g];
    assign dd_bus[32*g +: 32] = dd[g];
    assign dm_bus[32*g +: 32] = dm[g];
  end

  pio_gpio_port #(.NUM_SM(NUM_SM), .PIN_COUNT(32)) dut (
    .clk                 (clk),
    .reset               (reset),
    .in_smWriteValid     (sm_valid),
    .in_pinsWriteData    (pd_bus),
    .in_pinsWriteMask    (pm_bus),
    .in_pinDirsWriteData (dd_bus),
    .in_pinDirsWriteMask (dm_bus),
    .in_cpuWriteValid    (cpu_valid),
    .in_cpuPins          (cpu_pins),
    .in_cpuDirs          (cpu_dirs),
    .in_syncBypass       (sync_bypass),
    .in_conflictClear    (conflict_clear),
    .in_padIn            (pad_in),
    .out_padOut          (pad_out),
    .out_padOe           (pad_oe),
    .out_GPIO            (gpio),
    .out_conflict        (conflict)
  );

  int tests = 0;
  int fails = 0;

  // Model state
  logic [31:0] m_out = '0, m_oe = '0, m_conf = '0, m_h1 = '0, m_h2 = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Per bit: find the highest-index claiming SM and count claimers.
  task automatic model_update();
    logic [31:0] np, nd, flag;
    int po, pc, dow, dc;
    if (reset) begin
      m_out = '0; m_oe = '0; m_conf = '0; m_h1 = '0; m_h2 = '0;
    end else begin
      np = m_out; nd = m_oe; flag = '0;
      for (int b = 0; b < 32; b++) begin
        po = -1; pc = 0; dow = -1; dc = 0;
        for (int i = NUM_SM - 1; i >= 0; i--) begin
          if (sm_valid[i] && pm[i][b]) begin pc++; if (po < 0) po = i; end
          if (sm_valid[i] && dm[i][b]) begin dc++; if (dow < 0) dow = i; end
        end
        if (po >= 0) np[b] = pd[po][b];
        else if (cpu_valid) np[b] = cpu_pins[b];
        if (dow >= 0) nd[b] = dd[dow][b];
        else if (cpu_valid) nd[b] = cpu_dirs[b];
        if (pc >= 2 || dc >= 2) flag[b] = 1'b1;
      end
      m_out  = np;
      m_oe   = nd;
      m_conf = (m_conf & ~conflict_clear) | flag;
      m_h2   = m_h1;
      m_h1   = pad_in;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check("padOut", pad_out, m_out);
    check("padOe", pad_oe, m_oe);
    check("conflict", conflict, m_conf);
    check("GPIO", gpio, (m_h1 & sync_bypass) | (m_h2 & ~sync_bypass));
  endtask

  task automatic quiet();
    sm_valid = '0; cpu_valid = 1'b0; cpu_pins = '0; cpu_dirs = '0;
    conflict_clear = '0; pad_in = '0;
    for (int i = 0; i < NUM_SM; i++) begin pd[i] = '0; pm[i] = '0; dd[i] = '0; dm[i] = '0; end
  endtask

  initial begin
    // Reset with garbage on every input
    reset = 1'b1; sm_valid = '1; cpu_valid = 1'b1; cpu_pins = 32'hDEAD_BEEF; cpu_dirs = 32'hCAFE_F00D;
    sync_bypass = 32'h0F0F_0F0F; conflict_clear = '0; pad_in = 32'hFFFF_FFFF;
    for (int i = 0; i < NUM_SM; i++) begin
      pd[i] = $urandom; pm[i] = '1; dd[i] = $urandom; dm[i] = '1;
    end
    for (int c = 0; c < 2; c++) begin
      step();
      check("rst_padOut", pad_out, 32'h0);
      check("rst_padOe", pad_oe, 32'h0);
      check("rst_gpio", gpio, 32'h0);
      check("rst_conflict", conflict, 32'h0);
    end
    reset = 1'b0; quiet(); sync_bypass = '0;
    step();
    check("post_rst_padOut", pad_out, 32'h0);
    check("post_rst_conflict", conflict, 32'h0);

    // SM priority: SM3 beats SM1, collision flagged even on overlap
    sm_valid = 4'b1010;
    pm[1] = 32'h0000_00F0; pd[1] = 32'h0000_00F0;
    pm[3] = 32'h0000_00F0; pd[3] = 32'h0000_0050;
    step();
    check("prio_nibble", {28'h0, pad_out[7:4]}, 32'h5);
    check("prio_conflict", conflict, 32'h0000_00F0);
    quiet(); conflict_clear = '1;
    step();
    check("clear_all", conflict, 32'h0);

    // CPU vs SM on dirs
    quiet();
    sm_valid = 4'b0001; dm[0] = 32'h0000_0003; dd[0] = 32'h0000_0001;
    cpu_valid = 1'b1; cpu_dirs = 32'hFFFF_FFFF;
    step();
    check("cpu_vs_sm", pad_oe, 32'hFFFF_FFFD);
    sm_valid = 4'b0000;
    step();
    check("invalid_sm_ignored", pad_oe, 32'hFFFF_FFFF);

    // Hold
    quiet(); cpu_valid = 1'b1; cpu_pins = 32'hA5A5_A5A5;
    step();
    cpu_valid = 1'b0; pm[2] = 32'hFFFF_FFFF; pd[2] = 32'h0;  // invalid SM with a mask
    for (int c = 0; c < 10; c++) begin
      step();
      check("hold", pad_out, 32'hA5A5_A5A5);
    end

    // Sync latency
    quiet(); sync_bypass = 32'h0000_0001;
    repeat (3) step();
    pad_in = 32'h8000_0001;
    step();
    check("sync_1edge", gpio & 32'h8000_0001, 32'h0000_0001);
    step();
    check("sync_2edge", gpio & 32'h8000_0001, 32'h8000_0001);

    // Conflict W1C, set beats clear
    quiet(); conflict_clear = '1;
    step();
    quiet();
    sm_valid = 4'b0101; pm[0] = 32'h10; pm[2] = 32'h10;
    step();
    check("w1c_set", conflict & 32'h10, 32'h10);
    quiet();
    sm_valid = 4'b0110; dm[1] = 32'h10; dm[2] = 32'h10; conflict_clear = 32'h10;
    step();
    check("w1c_set_wins", conflict & 32'h10, 32'h10);
    quiet(); conflict_clear = 32'h10;
    step();
    check("w1c_clear", conflict & 32'h10, 32'h0);

    // Randomized traffic with occasional mid-stream resets
    for (int c = 0; c < 600; c++) begin
      reset          = ($urandom_range(0, 59) == 0);
      sm_valid       = 4'($urandom_range(0, 15));
      cpu_valid      = $urandom_range(0, 1) == 1;
      cpu_pins       = $urandom;
      cpu_dirs       = $urandom;
      conflict_clear = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0;
      pad_in         = $urandom;
      if ($urandom_range(0, 15) == 0) sync_bypass = $urandom;
      for (int i = 0; i < NUM_SM; i++) begin
        pd[i] = $urandom; dd[i] = $urandom;
        pm[i] = $urandom & $urandom & $urandom;
        dm[i] = $urandom & $urandom;
      end
      step();
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
